rvic_claim_core: RTL
====================

Name: rvic_claim_core

Overview:
Parametrised successor interrupt controller core with per-source level/edge gateways, priority threshold and a claim/complete handshake. Each source is held off from re-triggering until software completes it. It includes its own register file on the existing peripheral register bus. It sits between peripheral interrupt lines and the MCU external-interrupt input.

Parameters:
NumSrc, 32, number of sources (1..32); source IDs are 0..NumSrc-1.
PrioW, 8, priority width in bits (1..8); each priority occupies the low PrioW bits of its byte lane.
PipeTree, 0, 1 = extra register stage after the arbitration tree (adds 1 cycle of latency).

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
src_i  in  NumSrc  raw interrupt sources, synchronous to clk_i
irq_o  out  1  interrupt request to the MCU, registered
irq_id_o  out  8  ID of the current best source, registered, aligned with irq_o
reg_we_i  in  1  register write strobe
reg_re_i  in  1  register read strobe
reg_wdata_i  in  32  write data
reg_be_i  in  4  byte enables
reg_addr_i  in  32  byte address; bits [7:2] are decoded
reg_rdata_o  out  32  read data, combinational in the same cycle as reg_re_i; 0 when reg_re_i=0

Behaviour:
- Register map (word offsets):
  - 0x00 ENABLE: RW.
  - 0x04 PENDING: RO; write-1-to-clear.
  - 0x08 MODE: RW; 0 = level, 1 = rising edge.
  - 0x0C THRESHOLD: RW, [PrioW-1:0].
  - 0x10 CLAIM/COMPLETE.
  - 0x14 IN_SERVICE: RO.
  - 0x20 + 4k PRIO_k: sources 4k..4k+3 in bytes 0..3.
- Byte enables apply to all RW and W1C writes. Bits at or above NumSrc read as 0 and ignore writes. Unmapped addresses read 0.
- Reset: all registers, the src_q edge flops, the pipe stage, irq_o and irq_id_o are 0. Reset asserted mid-claim clears pending and in_service at the next clock edge.
- Gateway per source i:
  - trig = MODE[i] ? (src_i[i] & ~src_q[i]) : src_i[i].
  - pending[i] is set at edge N when trig=1, pending=0, in_service=0, and no claim of i occurs in that cycle.
  - Triggers during pending or in_service are dropped, including edge-mode edges.
  - Pending latches regardless of ENABLE.
- Eligibility: pending & enable & (prio > threshold). Priority 0 never interrupts.
- Arbitration:
  - Binary max-tree over all sources.
  - The higher priority wins; on a tie the lower ID wins.
  - Outputs {valid, id, prio}.
- Output:
  - irq_o = registered valid; irq_id_o = registered id (0 when not valid).
  - Latency from src_i sampled at edge N: pending set at N, irq_o/irq_id_o at N+1, or N+2 with PipeTree=1.
- Claim: read of 0x10.
  - The claim targets id = irq_id_o and is valid only if irq_o=1 and that source is still eligible this cycle.
  - Valid claim: rdata = {1'b1, 23'b0, id}; pending[id] is cleared and in_service[id] is set at the clock edge.
  - Invalid claim: rdata = 0, no state change.
  - irq_o reflects the claim at most 1 cycle later (2 with PipeTree=1).
- Complete: write of 0x10 with reg_be_i[0]=1.
  - in_service[wdata[7:0]] is cleared.
  - The write is ignored if the ID is >= NumSrc or the source is not in service.
  - A level source still high re-pends on the cycle after completion.
- Read and write in the same cycle: the write is ignored.
- Software W1C of pending[i] in the same cycle as a gateway set: the clear wins.

Decomposition:
- Package rvic_claim_pkg:
  - Register offset localparams.
  - arb_node_t packed struct {valid, id[7:0], prio[7:0]}.
  - MaxSrc=32.
- Sub-module rvic_prio_tree (params NumSrc, PrioW):
  - Combinational log2 max-tree.
  - Pads to a power of two with invalid nodes.
  - Tie goes to the lower ID.
- Register decode, gateways, claim/complete and output flops live in rvic_claim_core.

Test Plan:
1. Reset: hold rst_ni=0 for 3 clocks with src_i=all-ones -> irq_o=0, irq_id_o=0, all registers read 0.
2. Level path, src 5:
   - Setup: prio 3, enable, threshold 0; src_i[5]=1 at edge N -> PENDING=0x20 after N, irq_o=1 and irq_id_o=5 at N+1.
   - Claim read returns 0x8000_0005, then IN_SERVICE=0x20, PENDING=0, irq_o=0 next cycle.
   - No re-pend while src stays high; after complete (write 5) PENDING=0x20 one cycle later.
3. Tie and preemption:
   - Sources 3 and 9 at prio 4 -> irq_id_o=3.
   - Write PRIO9=5 -> irq_id_o=9 one cycle later.
   - Disable 9 -> irq_id_o=3.
4. Threshold: source 2 at prio 4 with THRESHOLD=4 -> irq_o=0; THRESHOLD=3 -> irq_o=1 next cycle. Prio 0 with threshold 0 -> never irq_o.
5. Edge mode, source 7:
   - A 1-cycle pulse -> pending. Claim, then pulse again while in service -> PENDING stays 0.
   - Complete 7 and pulse once -> PENDING=0x80.
   - A src held high for 10 cycles -> exactly one pend.
6. Stale claim and PipeTree=1:
   - irq_id_o=4, then W1C PENDING bit 4, then claim in the next cycle -> rdata=0 and in_service unchanged.
   - PipeTree=1 -> irq_o asserts at N+2.

Source files
------------

// File: rtl/rvic_claim_pkg.sv
// Shared definitions for the rvic claim/complete interrupt controller:
// register offsets, arbitration node type and small helpers.
package rvic_claim_pkg;

    localparam int MaxSrc = 32;

    localparam logic [7:0] OFF_ENABLE     = 8'h00;
    localparam logic [7:0] OFF_PENDING    = 8'h04;
    localparam logic [7:0] OFF_MODE       = 8'h08;
    localparam logic [7:0] OFF_THRESHOLD  = 8'h0C;
    localparam logic [7:0] OFF_CLAIM      = 8'h10;
    localparam logic [7:0] OFF_IN_SERVICE = 8'h14;
    localparam logic [7:0] OFF_PRIO_BASE  = 8'h20;

    typedef struct packed {
        logic       valid;
        logic [7:0] id;
        logic [7:0] prio;
    } arb_node_t;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // The left node always carries the lower IDs, so it keeps ties.
    function automatic arb_node_t arb_pick(input arb_node_t lo, input arb_node_t hi);
        return (hi.valid && (!lo.valid || (hi.prio > lo.prio))) ? hi : lo;
    endfunction

endpackage

// File: rtl/rvic_claim_if.sv
// Peripheral register bus used to reach the rvic register file.
interface rvic_claim_if;

    logic        reg_we_i;
    logic        reg_re_i;
    logic [31:0] reg_wdata_i;
    logic [3:0]  reg_be_i;
    logic [31:0] reg_addr_i;
    logic [31:0] reg_rdata_o;

    modport master (
        output reg_we_i, reg_re_i, reg_wdata_i, reg_be_i, reg_addr_i,
        input  reg_rdata_o
    );

    modport slave (
        input  reg_we_i, reg_re_i, reg_wdata_i, reg_be_i, reg_addr_i,
        output reg_rdata_o
    );

endinterface

// File: rtl/rvic_prio_tree.sv
// Combinational binary max-tree picking the highest-priority eligible source;
// padded to a power of two with invalid leaves, ties go to the lower ID.
module rvic_prio_tree
    import rvic_claim_pkg::*;
#(
    parameter int NumSrc = 32,
    parameter int PrioW  = 8
) (
    input  logic [NumSrc-1:0]            i_valid,
    input  logic [NumSrc-1:0][PrioW-1:0] i_prio,
    output arb_node_t                    o_best
);

    localparam int Leaves = 1 << $clog2(NumSrc);

    arb_node_t w_node [2*Leaves];

    // Heap layout: node n has children 2n and 2n+1, leaves start at Leaves.
    always_comb begin
        for (int k = 0; k < 2 * Leaves; k++) begin
            w_node[k] = '0;
        end
        for (int g = 0; g < NumSrc; g++) begin
            w_node[Leaves + g] = '{valid: i_valid[g], id: 8'(g), prio: 8'(i_prio[g])};
        end
        for (int n = Leaves - 1; n >= 1; n--) begin
            w_node[n] = arb_pick(w_node[2 * n], w_node[2 * n + 1]);
        end
    end

    assign o_best = w_node[1];

endmodule

// File: rtl/rvic_claim_core.sv
// Interrupt controller core: per-source level/edge gateways, enable/priority/
// threshold filtering, claim/complete handshake and its register file.
module rvic_claim_core
    import rvic_claim_pkg::*;
#(
    parameter int NumSrc   = 32,
    parameter int PrioW    = 8,
    parameter bit PipeTree = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumSrc-1:0] src_i,
    output logic              irq_o,
    output logic [7:0]        irq_id_o,
    rvic_claim_if.slave       reg_bus
);

    logic [NumSrc-1:0]            r_enable;
    logic [NumSrc-1:0]            r_pending;
    logic [NumSrc-1:0]            r_mode;
    logic [NumSrc-1:0]            r_in_service;
    logic [NumSrc-1:0]            r_src_q;
    logic [PrioW-1:0]             r_threshold;
    logic [NumSrc-1:0][PrioW-1:0] r_prio;
    logic                         r_irq;
    logic [7:0]                   r_irq_id;

    logic [7:0]                   w_off;
    logic [31:0]                  w_bmask;
    logic [31:0]                  w_wbits;
    logic                         w_wr;
    logic                         w_is_prio;
    logic [NumSrc-1:0]            w_prio_we;
    logic [NumSrc-1:0][PrioW-1:0] w_prio_wd;
    logic [MaxSrc-1:0][7:0]       w_prio_ext;
    logic [NumSrc-1:0]            w_elig;
    logic [MaxSrc-1:0]            w_elig_ext;
    logic [MaxSrc-1:0]            w_in_service_ext;
    logic                         w_claim_ok;
    logic [MaxSrc-1:0]            w_claim_ext;
    logic [7:0]                   w_cmp_id;
    logic [MaxSrc-1:0]            w_cmp_ext;
    logic [NumSrc-1:0]            w_trig;
    logic [NumSrc-1:0]            w_set;
    logic [NumSrc-1:0]            w_w1c;
    logic [NumSrc-1:0]            w_pending_n;
    logic [NumSrc-1:0]            w_in_service_n;
    arb_node_t                    w_tree;
    arb_node_t                    w_best;
    logic [31:0]                  w_prio_word;
    logic [31:0]                  w_rdata;
    logic                         w_unused;

    // Bus decode; a write colliding with a read is dropped.
    always_comb begin
        w_off     = {reg_bus.reg_addr_i[7:2], 2'b00};
        w_bmask   = be_mask(reg_bus.reg_be_i);
        w_wbits   = reg_bus.reg_wdata_i & w_bmask;
        w_wr      = reg_bus.reg_we_i & ~reg_bus.reg_re_i;
        w_is_prio = (w_off[7:5] == 3'b001);
    end

    for (genvar g = 0; g < NumSrc; g++) begin : g_prio_wr
        assign w_prio_we[g] = w_wr && (w_off == (OFF_PRIO_BASE + 8'(4 * (g / 4))))
                              && reg_bus.reg_be_i[g % 4];
        assign w_prio_wd[g] = reg_bus.reg_wdata_i[8 * (g % 4) +: PrioW];
    end

    for (genvar g = 0; g < MaxSrc; g++) begin : g_prio_ext
        if (g < NumSrc) begin : g_on
            assign w_prio_ext[g] = 8'(r_prio[g]);
        end else begin : g_off
            assign w_prio_ext[g] = 8'h00;
        end
    end

    // Eligibility: pending, enabled and strictly above threshold.
    always_comb begin
        for (int i = 0; i < NumSrc; i++) begin
            w_elig[i] = r_pending[i] & r_enable[i] & (r_prio[i] > r_threshold);
        end
        w_elig_ext       = 32'(w_elig);
        w_in_service_ext = 32'(r_in_service);
    end

    rvic_prio_tree #(
        .NumSrc (NumSrc),
        .PrioW  (PrioW)
    ) u_tree (
        .i_valid (w_elig),
        .i_prio  (r_prio),
        .o_best  (w_tree)
    );

    if (PipeTree) begin : g_pipe
        arb_node_t r_pipe;

        // Optional retiming stage after the arbitration tree.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_pipe <= '0;
            end else begin
                r_pipe <= w_tree;
            end
        end

        assign w_best = r_pipe;
    end else begin : g_nopipe
        assign w_best = w_tree;
    end

    // Claim validates the advertised ID against the live eligibility, so a
    // source withdrawn after irq_id_o was registered cannot be claimed.
    always_comb begin
        w_claim_ok  = reg_bus.reg_re_i & (w_off == OFF_CLAIM) & r_irq
                      & w_elig_ext[r_irq_id[4:0]];
        w_claim_ext = '0;
        if (w_claim_ok) begin
            w_claim_ext[r_irq_id[4:0]] = 1'b1;
        end else begin
            w_claim_ext = '0;
        end

        w_cmp_id  = reg_bus.reg_wdata_i[7:0];
        w_cmp_ext = '0;
        if (w_wr && (w_off == OFF_CLAIM) && reg_bus.reg_be_i[0]
            && (w_cmp_id < 8'(NumSrc)) && w_in_service_ext[w_cmp_id[4:0]]) begin
            w_cmp_ext[w_cmp_id[4:0]] = 1'b1;
        end else begin
            w_cmp_ext = '0;
        end
    end

    // Gateways; software clear and claim both override a new trigger.
    always_comb begin
        w_trig = src_i & (~r_mode | ~r_src_q);
        w_set  = w_trig & ~r_pending & ~r_in_service & ~w_claim_ext[NumSrc-1:0];
        w_w1c  = '0;
        if (w_wr && (w_off == OFF_PENDING)) begin
            w_w1c = w_wbits[NumSrc-1:0];
        end else begin
            w_w1c = '0;
        end
        w_pending_n    = (r_pending | w_set) & ~w_claim_ext[NumSrc-1:0] & ~w_w1c;
        w_in_service_n = (r_in_service | w_claim_ext[NumSrc-1:0]) & ~w_cmp_ext[NumSrc-1:0];
    end

    // Register state, gateway flops and registered interrupt outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_enable     <= '0;
            r_pending    <= '0;
            r_mode       <= '0;
            r_in_service <= '0;
            r_src_q      <= '0;
            r_threshold  <= '0;
            r_prio       <= '0;
            r_irq        <= 1'b0;
            r_irq_id     <= 8'h00;
        end else begin
            r_src_q      <= src_i;
            r_pending    <= w_pending_n;
            r_in_service <= w_in_service_n;
            if (w_wr && (w_off == OFF_ENABLE)) begin
                r_enable <= (r_enable & ~w_bmask[NumSrc-1:0]) | w_wbits[NumSrc-1:0];
            end
            if (w_wr && (w_off == OFF_MODE)) begin
                r_mode <= (r_mode & ~w_bmask[NumSrc-1:0]) | w_wbits[NumSrc-1:0];
            end
            if (w_wr && (w_off == OFF_THRESHOLD) && reg_bus.reg_be_i[0]) begin
                r_threshold <= reg_bus.reg_wdata_i[PrioW-1:0];
            end
            for (int i = 0; i < NumSrc; i++) begin
                if (w_prio_we[i]) begin
                    r_prio[i] <= w_prio_wd[i];
                end
            end
            r_irq    <= w_best.valid;
            r_irq_id <= w_best.valid ? w_best.id : 8'h00;
        end
    end

    // Read mux; zero whenever no read is strobed.
    always_comb begin
        w_prio_word = '0;
        for (int j = 0; j < 4; j++) begin
            w_prio_word[8 * j +: 8] = w_prio_ext[{w_off[4:2], 2'(j)}];
        end
        w_rdata = '0;
        if (reg_bus.reg_re_i) begin
            case (w_off)
                OFF_ENABLE:     w_rdata = 32'(r_enable);
                OFF_PENDING:    w_rdata = 32'(r_pending);
                OFF_MODE:       w_rdata = 32'(r_mode);
                OFF_THRESHOLD:  w_rdata = 32'(r_threshold);
                OFF_CLAIM:      w_rdata = w_claim_ok ? {1'b1, 23'b0, r_irq_id} : 32'h0000_0000;
                OFF_IN_SERVICE: w_rdata = 32'(r_in_service);
                default: begin
                    if (w_is_prio) begin
                        w_rdata = w_prio_word;
                    end else begin
                        w_rdata = 32'h0000_0000;
                    end
                end
            endcase
        end else begin
            w_rdata = 32'h0000_0000;
        end
    end

    assign reg_bus.reg_rdata_o = w_rdata;
    assign irq_o               = r_irq;
    assign irq_id_o            = r_irq_id;

    assign w_unused = ^{reg_bus.reg_addr_i[31:8], reg_bus.reg_addr_i[1:0], w_best.prio};

endmodule
